// File: rtl/csr_counter.sv
// Enable-gated free-running up-counter backing mcycle, minstret and mtime.
// The output port is the count register itself, so it can be deposited.
module csr_counter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  output logic [XLEN-1:0] out
);

  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  // resetn is active-high despite its name; it clears without a clock edge
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      out <= '0;
    end else if (enable) begin
      out <= out + ONE;
    end
  end

endmodule

// File: tb/tb_csr_counter.sv
// Bench for csr_counter: 64-bit and 4-bit instances, table vectors plus
// hand sequences for async reset, wrap and wide carry.
module tb_csr_counter;

  logic        clk;
  logic        rst64;
  logic        en64;
  logic [63:0] out64;
  logic        rst4;
  logic        en4;
  logic [3:0]  out4;

  int n_checks;
  int n_fail;

  logic [63:0] sb[$];

  typedef struct {
    logic        rst;
    logic        en;
    logic [63:0] exp;
  } vec_t;

  csr_counter #(.XLEN(64)) dut64 (
    .clk    (clk),
    .resetn (rst64),
    .enable (en64),
    .out    (out64)
  );

  csr_counter #(.XLEN(4)) dut4 (
    .clk    (clk),
    .resetn (rst4),
    .enable (en4),
    .out    (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [63:0] act);
    logic [63:0] e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      e = sb.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic apply64(input logic r, input logic e, input logic [63:0] x);
    @(negedge clk);
    rst64 = r;
    en64  = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    pop_check("vec64", out64);
  endtask

  vec_t vecs[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst64 = 1'b1;
    en64  = 1'b0;
    rst4  = 1'b1;
    en4   = 1'b0;
    #1;
    check("reset64", out64, 64'd0);
    check("reset4", {60'd0, out4}, 64'd0);

    // count 10, hold 5, reset, then gating pattern 1,0,1,1,0
    vecs.push_back('{1'b0, 1'b0, 64'd0});
    for (int i = 1; i <= 10; i++)
      vecs.push_back('{1'b0, 1'b1, 64'(i)});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 1'b0, 64'd10});
    vecs.push_back('{1'b1, 1'b1, 64'd0});
    vecs.push_back('{1'b0, 1'b1, 64'd1});
    vecs.push_back('{1'b0, 1'b0, 64'd1});
    vecs.push_back('{1'b0, 1'b1, 64'd2});
    vecs.push_back('{1'b0, 1'b1, 64'd3});
    vecs.push_back('{1'b0, 1'b0, 64'd3});
    foreach (vecs[i])
      apply64(vecs[i].rst, vecs[i].en, vecs[i].exp);

    // mid-cycle async assert with no clock edge
    @(negedge clk);
    en64 = 1'b1;
    #2;
    rst64 = 1'b1;
    #1;
    check("async_rst_same_step", out64, 64'd0);

    // wrap on the 4-bit instance
    @(negedge clk);
    rst64 = 1'b0;
    en64  = 1'b0;
    rst4  = 1'b0;
    en4   = 1'b1;
    sb.delete();
    for (int i = 1; i <= 17; i++) begin
      sb.push_back(64'(i % 16));
      @(posedge clk);
      #1;
      pop_check("wrap4", {60'd0, out4});
    end
    @(negedge clk);
    en4 = 1'b0;

    // wide carry across bit 31 and full wrap, via deposit
    dut64.out = 64'h0000_0000_FFFF_FFFF;
    en64 = 1'b1;
    sb.push_back(64'h0000_0001_0000_0000);
    @(posedge clk);
    #1;
    pop_check("carry32", out64);
    @(negedge clk);
    dut64.out = '1;
    sb.push_back(64'd0);
    @(posedge clk);
    #1;
    pop_check("wrap64", out64);

    // async reset mid-count from 7
    @(negedge clk);
    rst64 = 1'b1;
    #1;
    rst64 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
    end
    #1;
    check("count_to_7", out64, 64'd7);
    @(negedge clk);
    #2;
    rst64 = 1'b1;
    #1;
    check("rst_mid_count", out64, 64'd0);
    en64 = 1'bx;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", out64, 64'd0);
    end
    @(negedge clk);
    rst64 = 1'b0;
    en64  = 1'b1;
    @(posedge clk);
    #1;
    check("after_release", out64, 64'd1);
    check("inst4_idle", {60'd0, out4}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
